// File: rtl/mem_copy_pkg.sv
// Shared definitions for the word-copy bus initiator: FSM state encoding
// and the fixed bus constants used by the datapath.
package mem_copy_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_WAIT = 3'd2,
      WR_REQ  = 3'd3,
      WR_WAIT = 3'd4,
      FIN     = 3'd5
   } mem_copy_state_e;

   localparam logic [31:0] WORD_BYTES = 32'd4;
   localparam logic [3:0]  FULL_BE    = 4'hF;

endpackage

// File: rtl/mem_copy_master.sv
// Word-copy engine: on a start pulse it reads len_i words from a source
// address and writes each to a destination address, one bus transaction
// outstanding at a time, over the req/gnt/rvalid memory protocol.
// Optional feature macro: MEM_COPY_CHKSUM_EN adds chksum_o, the wrap-around
// sum of every word read without error during the current run.
module mem_copy_master
   import mem_copy_pkg::*;
#(
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [31:0]      src_addr_i,
   input  logic [31:0]      dst_addr_i,
   input  logic [LEN_W-1:0] len_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic             port_req_o,
   input  logic             port_gnt_i,
   input  logic             port_rvalid_i,
   output logic [31:0]      port_addr_o,
   output logic             port_we_o,
   output logic [3:0]       port_be_o,
   output logic [31:0]      port_wdata_o,
   input  logic [31:0]      port_rdata_i,
   input  logic             port_err_i
`ifdef MEM_COPY_CHKSUM_EN
   ,
   output logic [31:0]      chksum_o
`endif
);

   mem_copy_state_e  state_q;
   mem_copy_state_e  state_d;
   logic [31:0]      src_q;
   logic [31:0]      dst_q;
   logic [LEN_W-1:0] count_q;
   logic [31:0]      data_q;
   logic             err_q;

   // State register plus the run context (addresses, remaining count, data
   // buffer, sticky error); addresses advance only after a clean write.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         count_q <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  src_q   <= {src_addr_i[31:2], 2'b00};
                  dst_q   <= {dst_addr_i[31:2], 2'b00};
                  count_q <= len_i;
                  err_q   <= 1'b0;
               end
            end
            RD_WAIT: begin
               if (port_rvalid_i) begin
                  if (port_err_i) begin
                     err_q <= 1'b1;
                  end else begin
                     data_q <= port_rdata_i;
                  end
               end
            end
            WR_WAIT: begin
               if (port_rvalid_i) begin
                  if (port_err_i) begin
                     err_q <= 1'b1;
                  end else begin
                     src_q   <= src_q + WORD_BYTES;
                     dst_q   <= dst_q + WORD_BYTES;
                     count_q <= count_q - 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Next-state decode and bus outputs; request fields come straight from
   // registers so they hold steady while a grant is withheld.
   always_comb begin
      state_d      = state_q;
      port_req_o   = 1'b0;
      port_we_o    = 1'b0;
      port_addr_o  = '0;
      port_wdata_o = '0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = (len_i != '0) ? RD_REQ : FIN;
            end
         end
         RD_REQ: begin
            port_req_o  = 1'b1;
            port_addr_o = src_q;
            if (port_gnt_i) begin
               state_d = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (port_rvalid_i) begin
               state_d = port_err_i ? FIN : WR_REQ;
            end
         end
         WR_REQ: begin
            port_req_o   = 1'b1;
            port_we_o    = 1'b1;
            port_addr_o  = dst_q;
            port_wdata_o = data_q;
            if (port_gnt_i) begin
               state_d = WR_WAIT;
            end
         end
         WR_WAIT: begin
            if (port_rvalid_i) begin
               if (port_err_i || (count_q == LEN_W'(1))) begin
                  state_d = FIN;
               end else begin
                  state_d = RD_REQ;
               end
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy_o    = (state_q != IDLE) && (state_q != FIN);
   assign done_o    = (state_q == FIN);
   assign err_o     = err_q;
   assign port_be_o = FULL_BE;

`ifdef MEM_COPY_CHKSUM_EN
   logic [31:0] chksum_q;

   // Running sum of clean read data; cleared when a new run is accepted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         chksum_q <= '0;
      end else if ((state_q == IDLE) && start_i) begin
         chksum_q <= '0;
      end else if ((state_q == RD_WAIT) && port_rvalid_i && !port_err_i) begin
         chksum_q <= chksum_q + port_rdata_i;
      end
   end

   assign chksum_o = chksum_q;
`endif

endmodule

// File: tb/tb_mem_copy_master.sv
// Self-checking bench for mem_copy_master. A behavioural responder answers
// the bus with programmable grant/response delays and error injection; a
// reference model predicts timing, traffic and memory contents per run.
// Optional feature macro: MEM_COPY_CHKSUM_EN enables checksum checks.
module tb_mem_copy_master;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_i = 1'b0;
   logic [31:0] src_addr_i = '0;
   logic [31:0] dst_addr_i = '0;
   logic [15:0] len_i = '0;
   logic        busy_o;
   logic        done_o;
   logic        err_o;
   logic        port_req_o;
   logic        port_gnt_i;
   logic        port_rvalid_i;
   logic [31:0] port_addr_o;
   logic        port_we_o;
   logic [3:0]  port_be_o;
   logic [31:0] port_wdata_o;
   logic [31:0] port_rdata_i;
   logic        port_err_i;
`ifdef MEM_COPY_CHKSUM_EN
   logic [31:0] chksum_o;
`endif

   int compared = 0;
   int mismatched = 0;

   // Responder configuration, written only by the stimulus process.
   int gnt_wait = 0;
   int rv_wait = 0;
   int rd_err_abs = 0;
   int wr_err_abs = 0;

   // Source words live in src_mem, destination writes land in dst_mem.
   logic [31:0] src_mem [0:1023];
   logic [31:0] dst_mem [0:1023];

   // Responder state and cumulative traffic counters.
   logic        pending = 1'b0;
   logic [31:0] p_addr = '0;
   logic [31:0] p_wdata = '0;
   logic        p_we = 1'b0;
   int          req_cnt = 0;
   int          rv_cnt = 0;
   int          rd_total = 0;
   int          wr_total = 0;
   int          req_cycles = 0;
   int          stab_viol = 0;
   int          be_viol = 0;
   logic [31:0] rd_log [$];
   logic        prev_stall = 1'b0;
   logic [31:0] prev_addr = '0;
   logic [31:0] prev_wdata = '0;
   logic        prev_we = 1'b0;

   // Per-run observations.
   int   done_cyc;
   logic busy1;
   logic err1;
   logic busy_at_done;
   logic done_after;
   int   rd0, wr0, rq0, sv0, bv0, lg0;

   mem_copy_master #(.LEN_W(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_i       (start_i),
      .src_addr_i    (src_addr_i),
      .dst_addr_i    (dst_addr_i),
      .len_i         (len_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .err_o         (err_o),
      .port_req_o    (port_req_o),
      .port_gnt_i    (port_gnt_i),
      .port_rvalid_i (port_rvalid_i),
      .port_addr_o   (port_addr_o),
      .port_we_o     (port_we_o),
      .port_be_o     (port_be_o),
      .port_wdata_o  (port_wdata_o),
      .port_rdata_i  (port_rdata_i),
      .port_err_i    (port_err_i)
`ifdef MEM_COPY_CHKSUM_EN
      ,
      .chksum_o      (chksum_o)
`endif
   );

   // Free-running clock.
   always #5 clk = ~clk;

   assign port_gnt_i    = port_req_o && !pending && (req_cnt >= gnt_wait);
   assign port_rvalid_i = pending && (rv_cnt >= rv_wait);
   assign port_rdata_i  = (port_rvalid_i && !p_we) ? src_mem[p_addr[11:2]] : 32'h0;
   assign port_err_i    = port_rvalid_i &&
                          (p_we ? ((wr_total + 1) == wr_err_abs) : ((rd_total + 1) == rd_err_abs));

   // Memory responder: grants after gnt_wait request cycles, responds
   // rv_wait cycles after the grant, and logs traffic and protocol slips.
   always @(posedge clk) begin
      if (!rst_n) begin
         pending    <= 1'b0;
         req_cnt    <= 0;
         rv_cnt     <= 0;
         prev_stall <= 1'b0;
      end else begin
         if (port_req_o) begin
            req_cycles <= req_cycles + 1;
            if (port_be_o !== 4'hF) be_viol <= be_viol + 1;
            if (prev_stall && ((port_addr_o !== prev_addr) || (port_we_o !== prev_we) ||
                               (port_we_o && (port_wdata_o !== prev_wdata))))
               stab_viol <= stab_viol + 1;
         end
         prev_stall <= port_req_o && !port_gnt_i;
         prev_addr  <= port_addr_o;
         prev_we    <= port_we_o;
         prev_wdata <= port_wdata_o;
         if (port_req_o && port_gnt_i) begin
            pending <= 1'b1;
            p_addr  <= port_addr_o;
            p_we    <= port_we_o;
            p_wdata <= port_wdata_o;
            req_cnt <= 0;
            rv_cnt  <= 0;
         end else if (port_req_o) begin
            req_cnt <= req_cnt + 1;
         end
         if (port_rvalid_i) begin
            pending <= 1'b0;
            if (p_we) begin
               wr_total <= wr_total + 1;
               if (!port_err_i) dst_mem[p_addr[11:2]] <= p_wdata;
            end else begin
               rd_total <= rd_total + 1;
               rd_log.push_back(p_addr);
            end
         end else if (pending) begin
            rv_cnt <= rv_cnt + 1;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Counts cycles from cycle 1 of a run until done_o, bounded.
   task automatic waitDone();
      int cyc;
      cyc = 1;
      done_cyc = -1;
      while (cyc < 4000) begin
         if (done_o === 1'b1) begin
            done_cyc = cyc;
            break;
         end
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic applyStimulus(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                                input int g, input int r, input int re, input int we_);
      gnt_wait   = g;
      rv_wait    = r;
      rd_err_abs = (re == 0) ? 0 : rd_total + re;
      wr_err_abs = (we_ == 0) ? 0 : wr_total + we_;
      rd0 = rd_total;
      wr0 = wr_total;
      rq0 = req_cycles;
      sv0 = stab_viol;
      bv0 = be_viol;
      lg0 = rd_log.size();
      @(negedge clk);
      src_addr_i = s;
      dst_addr_i = d;
      len_i      = n;
      start_i    = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      busy1   = busy_o;
      err1    = err_o;
      waitDone();
      busy_at_done = busy_o;
      @(negedge clk);
      done_after = done_o;
   endtask

   // Reference model: predicts the outcome of a run from word count,
   // delays and injected errors, then compares against what was observed.
   task automatic checkRun(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                           input int g, input int r, input int re, input int we_);
      int reads_e, writes_e, good_e, goodrd_e, t, done_e, nn;
      logic err_e;
      logic [31:0] s_al, d_al, a, b, obs;
`ifdef MEM_COPY_CHKSUM_EN
      logic [31:0] sum;
`endif
      nn   = int'(n);
      s_al = {s[31:2], 2'b00};
      d_al = {d[31:2], 2'b00};
      t    = 2 + g + r;
      if (nn == 0) begin
         reads_e = 0; writes_e = 0; good_e = 0; goodrd_e = 0; err_e = 1'b0; done_e = 1;
      end else if (re != 0) begin
         reads_e = re; writes_e = re - 1; good_e = re - 1; goodrd_e = re - 1; err_e = 1'b1;
         done_e = 1 + (re - 1) * 2 * t + t;
      end else if (we_ != 0) begin
         reads_e = we_; writes_e = we_; good_e = we_ - 1; goodrd_e = we_; err_e = 1'b1;
         done_e = 1 + we_ * 2 * t;
      end else begin
         reads_e = nn; writes_e = nn; good_e = nn; goodrd_e = nn; err_e = 1'b0;
         done_e = 1 + nn * 2 * t;
      end
      checkOutput("done_cycle", done_cyc, done_e);
      checkOutput("busy_cycle1", busy1, nn != 0);
      checkOutput("busy_at_done", busy_at_done, 1'b0);
      checkOutput("done_one_cycle", done_after, 1'b0);
      checkOutput("err_flag", err_o, err_e);
      checkOutput("read_count", rd_total - rd0, reads_e);
      checkOutput("write_count", wr_total - wr0, writes_e);
      checkOutput("req_cycles", req_cycles - rq0, (reads_e + writes_e) * (g + 1));
      checkOutput("req_stable", stab_viol - sv0, 0);
      checkOutput("byte_enable", be_viol - bv0, 0);
      for (int i = 0; i < reads_e; i++) begin
         a   = s_al + 32'(4 * i);
         obs = ((lg0 + i) < rd_log.size()) ? rd_log[lg0 + i] : 32'hxxxx_xxxx;
         checkOutput("read_addr", obs, a);
      end
      for (int i = 0; i < good_e; i++) begin
         a = s_al + 32'(4 * i);
         b = d_al + 32'(4 * i);
         checkOutput("copied_word", dst_mem[b[11:2]], src_mem[a[11:2]]);
      end
`ifdef MEM_COPY_CHKSUM_EN
      sum = '0;
      for (int i = 0; i < goodrd_e; i++) begin
         a   = s_al + 32'(4 * i);
         sum = sum + src_mem[a[11:2]];
      end
      checkOutput("chksum", chksum_o, sum);
`else
      if (goodrd_e < 0) $display("[TB] unexpected negative read count");
`endif
   endtask

   initial begin
      logic [31:0] s, d;
      logic [15:0] n;
      int g, r, re, we_, mode, cyc;

      for (int i = 0; i < 1024; i++) src_mem[i] = $urandom;

      // Reset values.
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_busy", busy_o, 1'b0);
      checkOutput("rst_done", done_o, 1'b0);
      checkOutput("rst_err", err_o, 1'b0);
      checkOutput("rst_req", port_req_o, 1'b0);
      checkOutput("rst_we", port_we_o, 1'b0);
      checkOutput("rst_addr", port_addr_o, 32'h0);
      checkOutput("rst_wdata", port_wdata_o, 32'h0);
      checkOutput("rst_be", port_be_o, 4'hF);
`ifdef MEM_COPY_CHKSUM_EN
      checkOutput("rst_chksum", chksum_o, 32'h0);
`endif
      rst_n = 1'b1;

      // Four words, zero-wait responder.
      for (int i = 0; i < 4; i++) src_mem[(32'h100 >> 2) + i] = 32'hA0 + 32'(i);
      applyStimulus(32'h100, 32'h200, 16'd4, 0, 0, 0, 0);
      checkRun(32'h100, 32'h200, 16'd4, 0, 0, 0, 0);

      // Zero-length run.
      applyStimulus(32'h300, 32'h800, 16'd0, 0, 0, 0, 0);
      checkRun(32'h300, 32'h800, 16'd0, 0, 0, 0, 0);

      // Grant withheld three cycles on every request.
      applyStimulus(32'h140, 32'h940, 16'd2, 3, 0, 0, 0);
      checkRun(32'h140, 32'h940, 16'd2, 3, 0, 0, 0);

      // Error on second read response, then a clean run clears err_o.
      applyStimulus(32'h180, 32'hA00, 16'd3, 0, 0, 2, 0);
      checkRun(32'h180, 32'hA00, 16'd3, 0, 0, 2, 0);
      applyStimulus(32'h1C0, 32'hA80, 16'd1, 0, 0, 0, 0);
      checkOutput("err_cleared_on_start", err1, 1'b0);
      checkRun(32'h1C0, 32'hA80, 16'd1, 0, 0, 0, 0);

      // Source address wraps past the top of the address space.
      applyStimulus(32'hFFFF_FFFC, 32'h0000_0C00, 16'd2, 1, 1, 0, 0);
      checkRun(32'hFFFF_FFFC, 32'h0000_0C00, 16'd2, 1, 1, 0, 0);
      checkOutput("wrap_addr", ((lg0 + 1) < rd_log.size()) ? rd_log[lg0 + 1] : 32'hxxxx_xxxx, 32'h0);

      // Error on a write response.
      s = $urandom;
      d = $urandom;
      applyStimulus(s, d, 16'd3, 1, 0, 0, 2);
      checkRun(s, d, 16'd3, 1, 0, 0, 2);

      // Start during done is ignored; start in the following cycle is taken.
      gnt_wait = 0; rv_wait = 0; rd_err_abs = 0; wr_err_abs = 0;
      @(negedge clk);
      src_addr_i = 32'h200; dst_addr_i = 32'hE00; len_i = 16'd1; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      waitDone();
      start_i = 1'b1;
      @(negedge clk);
      checkOutput("start_at_done_ignored", busy_o, 1'b0);
      @(negedge clk);
      start_i = 1'b0;
      checkOutput("back_to_back_busy", busy_o, 1'b1);
      waitDone();
      checkOutput("back_to_back_done", done_cyc, 5);
      @(negedge clk);

      // Reset while a write request is pending.
      gnt_wait = 6;
      @(negedge clk);
      src_addr_i = 32'h240; dst_addr_i = 32'hB00; len_i = 16'd3; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      cyc = 0;
      while (!(port_req_o && port_we_o) && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput("reached_write_req", port_req_o && port_we_o, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("midrun_rst_req", port_req_o, 1'b0);
      checkOutput("midrun_rst_busy", busy_o, 1'b0);
      rst_n = 1'b1;
      s = $urandom;
      d = $urandom;
      applyStimulus(s, d, 16'd3, 0, 1, 0, 0);
      checkRun(s, d, 16'd3, 0, 1, 0, 0);

      // Randomized runs.
      for (int k = 0; k < 8; k++) begin
         n    = 16'($urandom_range(1, 6));
         g    = $urandom_range(0, 2);
         r    = $urandom_range(0, 2);
         mode = $urandom_range(0, 3);
         re   = (mode == 1) ? $urandom_range(1, int'(n)) : 0;
         we_  = (mode == 2) ? $urandom_range(1, int'(n)) : 0;
         s    = $urandom;
         d    = $urandom;
         for (int i = 0; i < 1024; i++) src_mem[i] = $urandom;
         applyStimulus(s, d, n, g, r, re, we_);
         checkRun(s, d, n, g, r, re, we_);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mem_copy_master.md
# mem_copy_master

Word-copy engine acting as a bus initiator on the same req/gnt/rvalid memory protocol that `mem_mod` answers as a responder. On a start pulse it reads `len_i` words from a source address and writes each one to a destination address, one transaction outstanding at a time. It sits beside the core in the fault-tolerant SoC and moves checkpoint regions (for example, state saved around the safe PC) between memory areas without core involvement.

## Interface
Parameters:
- LEN_W, 16, width of the word-count input; a single run copies at most 2^LEN_W-1 words.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock; everything is sampled on the rising edge
- rst_n  in  1  synchronous active-low reset
- start_i  in  1  one-cycle start request; ignored while busy_o=1
- src_addr_i  in  32  source byte address, sampled on start; bits [1:0] are forced to 0
- dst_addr_i  in  32  destination byte address, sampled on start; bits [1:0] are forced to 0
- len_i  in  LEN_W  number of words to copy, sampled on start
- busy_o  out  1  high from the cycle after an accepted start until done_o
- done_o  out  1  one-cycle pulse when a run ends, whether it completed or aborted
- err_o  out  1  sticky error flag; cleared by the next accepted start
- port_req_o  out  1  bus request
- port_gnt_i  in  1  grant
- port_rvalid_i  in  1  response valid, returned for both reads and writes
- port_addr_o  out  32  word-aligned bus address
- port_we_o  out  1  1 = write
- port_be_o  out  4  byte enables; always 4'hF
- port_wdata_o  out  32  write data
- port_rdata_i  in  32  read data, valid while port_rvalid_i=1
- port_err_i  in  1  response error, sampled with port_rvalid_i
- chksum_o  out  32  present only when MEM_COPY_CHKSUM_EN is defined

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN.
- IDLE:
  - start_i=1 with len_i≠0 latches src, dst and count, clears err_o, and moves to RD_REQ.
  - start_i=1 with len_i=0 moves to FIN with no bus traffic.
- RD_REQ:
  - Drives req=1, we=0, addr=src.
  - Holds all outputs stable until gnt, then moves to RD_WAIT.
- RD_WAIT:
  - On rvalid, captures rdata into the data buffer and moves to WR_REQ.
  - If port_err_i=1, sets err_o and moves to FIN.
- WR_REQ:
  - Drives req=1, we=1, addr=dst, wdata=buffer.
  - Holds all outputs stable until gnt, then moves to WR_WAIT.
- WR_WAIT:
  - On rvalid: src+=4, dst+=4, count-=1.
  - If count reaches 0, moves to FIN; otherwise moves to RD_REQ.
  - If port_err_i=1, sets err_o and moves to FIN without decrementing.
- FIN: done_o=1 for one cycle, busy_o=0, then IDLE.
- Address arithmetic is modulo 2^32; incrementing from 32'hFFFF_FFFC wraps to 32'h0000_0000.
- port_req_o is never asserted outside RD_REQ and WR_REQ.
- A rvalid that arrives in any state other than RD_WAIT or WR_WAIT is ignored.
- Reset values: busy_o=0, done_o=0, err_o=0, port_req_o=0, port_we_o=0, port_addr_o=0, port_wdata_o=0, port_be_o=4'hF, chksum_o=0, state=IDLE.
- Reset in the middle of a run drops port_req_o at the next edge and discards the run. The attached memory is reset by the same rst_n.

## Timing
- Accepted start in cycle 0 gives busy_o=1 and port_req_o=1 in cycle 1.
- With gnt in the same cycle as req and rvalid one cycle after gnt, each word takes 4 cycles: read grant, read response, write grant, write response.
- done_o rises in the cycle after the final write rvalid. busy_o falls in that same cycle.
- A run of N words with zero-wait memory: done_o in cycle 4N+1.
- The len_i=0 case gives done_o in cycle 1.
- A back-to-back start in the cycle after done_o is accepted.
- A start asserted in the same cycle as done_o is ignored.
- Each wait cycle without gnt or rvalid adds exactly one cycle.

## Configuration
- MEM_COPY_CHKSUM_EN defined:
  - chksum_o exists.
  - It is cleared on an accepted start and accumulates the 32-bit wrap-around sum of every word read without error.
  - It is stable and valid from done_o onward.
- MEM_COPY_CHKSUM_EN undefined:
  - No chksum_o port and no accumulator logic.
  - All other behaviour is identical.

## Structure
- Package mem_copy_pkg holds:
  - the state enum `mem_copy_state_e`
  - the constant WORD_BYTES=4
  - the constant FULL_BE=4'hF
- No sub-module. The checksum adder is inline, guarded by the macro.

## Test plan
- src=0x100, dst=0x200, len=4, zero-wait responder holding 0xA0..0xA3 → memory 0x200..0x20C = 0xA0..0xA3, done_o in cycle 17, chksum_o=0x286.
- len=0 → done_o in cycle 1, port_req_o never high, err_o=0.
- Responder withholds gnt for 3 cycles on every request, len=2 → addr/we/wdata stable while req is high, done_o in cycle 21.
- port_err_i=1 on the second read response, len=3 → err_o=1, only one write issued, done_o pulses, the next start clears err_o.
- src=0xFFFF_FFFC, len=2 → second read address is 0x0000_0000.
- rst_n=0 while in WR_REQ → port_req_o=0 and busy_o=0 at the next edge; a start after reset copies correctly.
